// File: rtl/craps_pkg.sv
// Shared widths, FSM encoding and sum constants for the craps dice path.
package craps_pkg;

  localparam int DIE_W = 3;
  localparam int SUM_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW_A = 2'd1,
    ST_DRAW_B = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [SUM_W-1:0] SUM_TWO    = 4'd2;
  localparam logic [SUM_W-1:0] SUM_THREE  = 4'd3;
  localparam logic [SUM_W-1:0] SUM_SEVEN  = 4'd7;
  localparam logic [SUM_W-1:0] SUM_ELEVEN = 4'd11;
  localparam logic [SUM_W-1:0] SUM_TWELVE = 4'd12;

endpackage

// File: rtl/die_sampler.sv
// Maps one random byte to a die face: low 3 bits 1..6 are taken as-is, 0/7 are
// rejected unless this is the last allowed draw, where 0 -> 1 and 7 -> 2. Combinational.
module die_sampler
  import craps_pkg::*;
(
  input  logic [7:0]       rnd_byte,
  input  logic             last_draw,
  output logic             accept,
  output logic [DIE_W-1:0] die_val
);

  logic [2:0] c;
  logic       unused_hi;

  assign c         = rnd_byte[2:0];
  assign unused_hi = ^rnd_byte[7:3];

  always_comb begin
    accept  = 1'b0;
    die_val = '0;
    if (c != 3'd0 && c != 3'd7) begin
      accept  = 1'b1;
      die_val = c;
    end else if (last_draw) begin
      accept  = 1'b1;
      die_val = (c == 3'd0) ? 3'd1 : 3'd2;
    end
  end

endmodule

// File: rtl/dice_roll_unit.sv
// Rolls two dice from the LFSR byte stream; roll_done 3+ cycles after roll_start.
// Stalls with rnd_req held high while rnd_valid is low; roll_start ignored while busy.
module dice_roll_unit
  import craps_pkg::*;
#(
  parameter int MAX_DRAWS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             roll_start,
  input  logic             rnd_valid,
  input  logic [7:0]       rnd_data,
  output logic             rnd_req,
  output logic             busy,
  output logic [DIE_W-1:0] die_a,
  output logic [DIE_W-1:0] die_b,
  output logic [SUM_W-1:0] sum,
  output logic             natural,
  output logic             craps,
  output logic             roll_done
);

  localparam logic [7:0] LAST_IDX = 8'(MAX_DRAWS - 1);

  state_t           state;
  logic [7:0]       draw_cnt;
  logic [DIE_W-1:0] shadow_a;
  logic             last_draw;
  logic             accept;
  logic [DIE_W-1:0] die_val;
  logic             take;
  logic [SUM_W-1:0] next_sum;

  assign last_draw = (draw_cnt == LAST_IDX);
  assign take      = rnd_req && rnd_valid;
  assign next_sum  = SUM_W'(shadow_a) + SUM_W'(die_val);

  die_sampler u_sampler (
    .rnd_byte  (rnd_data),
    .last_draw (last_draw),
    .accept    (accept),
    .die_val   (die_val)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      draw_cnt  <= '0;
      shadow_a  <= '0;
      rnd_req   <= 1'b0;
      busy      <= 1'b0;
      die_a     <= '0;
      die_b     <= '0;
      sum       <= '0;
      natural   <= 1'b0;
      craps     <= 1'b0;
      roll_done <= 1'b0;
    end else begin
      roll_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (roll_start) begin
            state    <= ST_DRAW_A;
            draw_cnt <= '0;
            rnd_req  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_DRAW_A: begin
          if (take) begin
            if (accept) begin
              shadow_a <= die_val;
              draw_cnt <= '0;
              state    <= ST_DRAW_B;
            end else begin
              draw_cnt <= draw_cnt + 8'd1;
            end
          end
        end
        ST_DRAW_B: begin
          if (take) begin
            if (accept) begin
              // Publish everything on the same edge so the consumer sees a coherent roll.
              die_a     <= shadow_a;
              die_b     <= die_val;
              sum       <= next_sum;
              natural   <= (next_sum == SUM_SEVEN) || (next_sum == SUM_ELEVEN);
              craps     <= (next_sum == SUM_TWO) || (next_sum == SUM_THREE) ||
                           (next_sum == SUM_TWELVE);
              roll_done <= 1'b1;
              rnd_req   <= 1'b0;
              state     <= ST_DONE;
            end else begin
              draw_cnt <= draw_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          rnd_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dice_roll_unit.md
Name: dice_roll_unit

Overview:
Consumer of the 8-bit LFSR random stream. On a roll request it pulls bytes from the random source over a req/valid handshake and converts them to two fair dice values (1..6) by rejection sampling. It then presents the dice, their sum and come-out classification flags to the game controller with a one-cycle done pulse. It sits between the LFSR and the craps game FSM.

Parameters:
MAX_DRAWS, 16, maximum bytes consumed per die before the fallback mapping is forced (range 1..255)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
roll_start  input  1  single-cycle roll request from game FSM
rnd_valid  input  1  random byte available on rnd_data
rnd_data  input  8  random byte from LFSR
rnd_req  output  1  request for a random byte
busy  output  1  roll in progress
die_a  output  3  first die value, 1..6
die_b  output  3  second die value, 1..6
sum  output  4  die_a + die_b, 2..12
natural  output  1  sum is 7 or 11
craps  output  1  sum is 2, 3 or 12
roll_done  output  1  one-cycle pulse; outputs valid and stable from this cycle

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clock. All outputs are cleared: die_a=0, die_b=0, sum=0, natural=0, craps=0, roll_done=0, busy=0, rnd_req=0. State goes to IDLE and the draw counter is 0.
- States are IDLE, DRAW_A, DRAW_B, DONE.
- IDLE:
  - roll_start=1 moves to DRAW_A and clears the draw counter.
  - busy is 0. rnd_req is 0.
- DRAW_A and DRAW_B:
  - rnd_req=1 and busy=1 are registered outputs, asserted from the first cycle in the state.
  - A byte is accepted in any cycle with rnd_req=1 and rnd_valid=1. rnd_valid while rnd_req=0 is ignored.
  - Let c = rnd_data[2:0].
  - If c is 1..6, the die takes value c.
  - If c is 0 or 7, the byte is rejected, the draw counter increments, and the block requests again.
  - If the rejected byte is draw number MAX_DRAWS (counter == MAX_DRAWS-1), the fallback is forced: c=0 gives die 1, c=7 gives die 2.
  - Once the die is set, DRAW_A moves to DRAW_B and clears the counter; DRAW_B moves to DONE.
  - rnd_req stays high continuously across consecutive draws and across the A to B transition. It drops in the cycle after the B die is set.
- DONE (exactly one cycle):
  - roll_done=1 and busy=1.
  - sum, natural and craps are registered in the same cycle as die_b, so all outputs change together and are coherent when roll_done=1.
  - Next state is IDLE.
- Output hold: die_a, die_b, sum, natural and craps hold their values until the next roll's DONE.
  - die_a does not visibly change mid-roll; it goes through an internal shadow register and is published at DONE.
- Minimum latency: roll_start at cycle 0 with rnd_valid always high and both bytes accepted gives roll_done at cycle 3.
- roll_start while busy=1, including during DONE, is ignored. No queueing.
- Arithmetic: sum is 4-bit, unsigned, with no overflow possible (maximum 12).
- Reset mid-roll aborts the roll. No roll_done is issued and the outputs return to their reset values.
- The source may hold rnd_valid high indefinitely. Each accepting cycle consumes exactly one byte.

Decomposition:
- Shared package (craps_pkg):
  - state encoding constants (2 bits)
  - DIE_W=3, SUM_W=4
  - sum constants for 7, 11, 2, 3 and 12
- Sub-module die_sampler:
  - Combinational.
  - Inputs: rnd byte, last_draw flag.
  - Outputs: accept flag and die value (3 bits).
  - Holds the rejection and fallback mapping.
- Top level holds the FSM, draw counter, shadow register and classifier.

Test Plan:
1. Reset, then roll_start with rnd_valid=1 and bytes 0x03, 0x04 -> roll_done at cycle 3; die_a=3, die_b=4, sum=7, natural=1, craps=0.
2. Rejection: bytes 0x07, 0x08, 0x05, 0x06 -> 2 rejects then die_a=5, 4th byte gives die_b=6; sum=11, natural=1; roll_done at cycle 5.
3. Fallback with MAX_DRAWS=4: 4 bytes of 0xFF for die A, then 0x01 -> die_a=2 (forced), die_b=1, sum=3, craps=1.
4. Handshake stall: rnd_valid low for 10 cycles after the request -> rnd_req held at 1, busy=1, no byte consumed, no roll_done; on release, completes normally.
5. roll_start pulsed during DRAW_B and during DONE -> ignored; exactly one roll_done; the next roll_start in IDLE starts a new roll.
6. Assert reset during DRAW_B -> all outputs 0 asynchronously, no roll_done; the next roll with bytes 0x01, 0x06 gives sum=7.
